mem_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of the execute unit.
- Registers the EX results: ALU result, store data, opcode, funct3 and rd.
- Performs loads and stores on the data-memory bus using a req/ack handshake, with byte-lane alignment and sign/zero extension.
- Presents the write-back result, which is also the EX/MEM forwarding source (rd_ex_mem / rd_data_ex_mem), and stalls upstream while a bus access is outstanding.

---
 rtl/mem_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage that sits directly after the execute unit.
// It registers the EX results and handles non-memory instructions in one
// cycle. Loads and stores go out on a req/ack data-memory bus. The stage
// aligns stores into byte lanes, extracts loads from byte lanes with sign
// or zero extension, flags misaligned accesses, and aborts an access that
// never receives an ack.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   valid_i         EX presents a valid instruction
//   ready_o         stage can accept (high only while IDLE)
//   alu_out_i       ALU result / effective address
//   rs2_data_i      store data
//   opcode_i        instruction opcode
//   funct3_i        instruction funct3
//   rd_i            destination register
//   dmem_*          data-memory bus (req/we/addr/be/wdata out, rdata/ack in)
//   wb_valid        one-cycle pulse per retired instruction
//   wb_we           register-file write enable
//   wb_rd           destination register (0 whenever wb_we is 0)
//   wb_data         write-back value, also the EX/MEM forwarding source
//   misalign_o      one-cycle pulse on a misaligned access
//   bus_err_o       one-cycle pulse on an ack timeout
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] rs2_data_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The timeout counter's final value. The counter is already 0 in the
    // first request cycle, so expiry happens when it reaches TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;

    logic        is_load;
    logic        is_store;
    logic        f3_legal;
    logic        misaligned;
    logic        alu_we;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_value;

    assign ready_o = (state == IDLE);

    // Classify the incoming instruction. Alignment is judged only for legal
    // funct3 codes; an illegal funct3 retires as a plain no-op.
    always_comb begin
        is_load    = (opcode_i == OP_LOAD);
        is_store   = (opcode_i == OP_STORE);
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        if (is_load) begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else if (is_store) begin
            f3_legal = (funct3_i <= 3'b010);
        end
        case (funct3_i[1:0])
            2'b01:   misaligned = alu_out_i[0];
            2'b10:   misaligned = (alu_out_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        case (opcode_i)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                alu_we = (rd_i != 5'd0);
            default:
                alu_we = 1'b0;
        endcase
    end

    // Store lane formatting: data is replicated across lanes so the byte
    // enables alone select where the memory writes.
    always_comb begin
        store_be    = 4'b0000;
        store_wdata = rs2_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                store_be    = 4'b0001 << alu_out_i[1:0];
                store_wdata = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                store_be    = alu_out_i[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{rs2_data_i[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = rs2_data_i;
            end
        endcase
    end

    // Load extraction uses the funct3 and address lane captured at accept,
    // because upstream may have moved on by the time the ack arrives.
    always_comb begin
        logic [7:0]  byte_val;
        logic [15:0] half_val;
        case (lane_q)
            2'd0:    byte_val = dmem_rdata[7:0];
            2'd1:    byte_val = dmem_rdata[15:8];
            2'd2:    byte_val = dmem_rdata[23:16];
            default: byte_val = dmem_rdata[31:24];
        endcase
        half_val = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  load_value = {{24{byte_val[7]}}, byte_val};
            3'b001:  load_value = {{16{half_val[15]}}, half_val};
            3'b100:  load_value = {24'd0, byte_val};
            3'b101:  load_value = {16'd0, half_val};
            default: load_value = dmem_rdata;
        endcase
    end

    // Main FSM. IDLE retires non-memory, illegal and misaligned instructions
    // immediately, or launches a bus access. BUSY waits for the ack or the
    // timeout. The bus fields stay untouched during BUSY so they are stable
    // until the ack arrives. An ack wins over a timeout on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmo_cnt    <= 8'd0;
            f3_q       <= 3'd0;
            lane_q     <= 2'd0;
            rd_q       <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        tmo_cnt <= 8'd0;
                        if ((is_load || is_store) && f3_legal && !misaligned) begin
                            state      <= BUSY;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {alu_out_i[31:2], 2'b00};
                            dmem_be    <= is_store ? store_be : 4'b0000;
                            dmem_wdata <= is_store ? store_wdata : 32'd0;
                            f3_q       <= funct3_i;
                            lane_q     <= alu_out_i[1:0];
                            rd_q       <= rd_i;
                        end else if (is_load || is_store) begin
                            wb_valid   <= 1'b1;
                            wb_we      <= 1'b0;
                            wb_rd      <= 5'd0;
                            wb_data    <= alu_out_i;
                            misalign_o <= f3_legal && misaligned;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= alu_we;
                            wb_rd    <= alu_we ? rd_i : 5'd0;
                            wb_data  <= alu_out_i;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        if (dmem_we) begin
                            wb_we <= 1'b0;
                            wb_rd <= 5'd0;
                        end else begin
                            wb_we   <= (rd_q != 5'd0);
                            wb_rd   <= rd_q;
                            wb_data <= load_value;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_we     <= 1'b0;
                        wb_rd     <= 5'd0;
                        bus_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed testbench for mem_stage. Each vector drives one instruction. The
// expected values are worked out by hand from the address, the data and the
// opcode. Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_out_i;
    logic [31:0] rs2_data_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_o;
    logic        bus_err_o;

    int checks;
    int passes;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .alu_out_i  (alu_out_i),
        .rs2_data_i (rs2_data_i),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .rd_i       (rd_i),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advances one rising edge and settles 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for exactly one edge, then drops valid
    task automatic applyStimulus(input logic [6:0] op, input logic [31:0] alu,
                                 input logic [31:0] rs2, input logic [2:0] f3,
                                 input logic [4:0] rd);
        opcode_i   = op;
        alu_out_i  = alu;
        rs2_data_i = rs2;
        funct3_i   = f3;
        rd_i       = rd;
        valid_i    = 1'b1;
        step();
        valid_i    = 1'b0;
    endtask

    // Runs one load with the ack already high, so it completes on the edge
    // after accept
    task automatic loadVector(input string tag, input logic [31:0] addr,
                              input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] exp_data, input logic exp_we);
        applyStimulus(OP_LOAD, addr, 32'd0, f3, rd);
        checkOutput({tag, "_req"}, 32'(dmem_req), 32'd1);
        checkOutput({tag, "_nowb"}, 32'(wb_valid), 32'd0);
        step();
        checkOutput({tag, "_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, "_data"}, wb_data, exp_data);
        checkOutput({tag, "_we"}, 32'(wb_we), 32'(exp_we));
        checkOutput({tag, "_rd"}, 32'(wb_rd), exp_we ? 32'(rd) : 32'd0);
    endtask

    initial begin
        int cnt;
        checks     = 0;
        passes     = 0;
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        alu_out_i  = 32'd0;
        rs2_data_i = 32'd0;
        opcode_i   = 7'd0;
        funct3_i   = 3'd0;
        rd_i       = 5'd0;
        dmem_rdata = 32'd0;
        dmem_ack   = 1'b0;

        // Reset state
        step();
        step();
        checkOutput("rst_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_addr", dmem_addr, 32'd0);
        checkOutput("rst_wbvalid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wbdata", wb_data, 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        rst_n = 1'b1;
        step();

        // ADD retires in one cycle, then wb_data holds its value
        applyStimulus(OP_REG, 32'h1234, 32'd0, 3'd0, 5'd5);
        checkOutput("add_valid", 32'(wb_valid), 32'd1);
        checkOutput("add_we", 32'(wb_we), 32'd1);
        checkOutput("add_rd", 32'(wb_rd), 32'd5);
        checkOutput("add_data", wb_data, 32'h1234);
        checkOutput("add_req", 32'(dmem_req), 32'd0);
        step();
        checkOutput("add_pulse", 32'(wb_valid), 32'd0);
        checkOutput("add_hold", wb_data, 32'h1234);

        // Branch and LUI to x0 do not write
        applyStimulus(OP_BR, 32'h40, 32'd0, 3'd0, 5'd3);
        checkOutput("br_we", 32'(wb_we), 32'd0);
        checkOutput("br_rd", 32'(wb_rd), 32'd0);
        applyStimulus(OP_LUI, 32'h5000, 32'd0, 3'd0, 5'd0);
        checkOutput("luix0_we", 32'(wb_we), 32'd0);

        // sb to 0x103: top lane, byte replicated, ack on the third cycle
        applyStimulus(OP_STORE, 32'h103, 32'hAABBCCDD, 3'b000, 5'd9);
        checkOutput("sb_req", 32'(dmem_req), 32'd1);
        checkOutput("sb_we", 32'(dmem_we), 32'd1);
        checkOutput("sb_addr", dmem_addr, 32'h100);
        checkOutput("sb_be", 32'(dmem_be), 32'h8);
        checkOutput("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
        checkOutput("sb_ready0", 32'(ready_o), 32'd0);
        step();
        checkOutput("sb_ready1", 32'(ready_o), 32'd0);
        checkOutput("sb_stable", 32'(dmem_be), 32'h8);
        step();
        checkOutput("sb_ready2", 32'(ready_o), 32'd0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checkOutput("sb_done_req", 32'(dmem_req), 32'd0);
        checkOutput("sb_wbvalid", 32'(wb_valid), 32'd1);
        checkOutput("sb_wbwe", 32'(wb_we), 32'd0);
        checkOutput("sb_ready", 32'(ready_o), 32'd1);

        // sh to the upper half, and sw
        applyStimulus(OP_STORE, 32'h102, 32'h1234ABCD, 3'b001, 5'd0);
        checkOutput("sh_be", 32'(dmem_be), 32'hC);
        checkOutput("sh_wdata", dmem_wdata, 32'hABCDABCD);
        dmem_ack = 1'b1;
        step();
        applyStimulus(OP_STORE, 32'h200, 32'hCAFEF00D, 3'b010, 5'd0);
        checkOutput("sw_be", 32'(dmem_be), 32'hF);
        checkOutput("sw_wdata", dmem_wdata, 32'hCAFEF00D);
        step();

        // Loads: ack held high throughout, so it is ignored while idle and
        // completes each access on the first request cycle
        dmem_rdata = 32'h80FF7F01;
        loadVector("lb", 32'h102, 3'b000, 5'd1, 32'hFFFFFFFF, 1'b1);
        loadVector("lbu", 32'h103, 3'b100, 5'd2, 32'h00000080, 1'b1);
        loadVector("lh", 32'h100, 3'b001, 5'd3, 32'h00007F01, 1'b1);
        loadVector("lhu", 32'h102, 3'b101, 5'd4, 32'h000080FF, 1'b1);
        loadVector("lwx0", 32'h100, 3'b010, 5'd0, 32'h80FF7F01, 1'b0);
        dmem_ack = 1'b0;

        // Misaligned lw and sh
        applyStimulus(OP_LOAD, 32'h202, 32'd0, 3'b010, 5'd6);
        checkOutput("mis_lw_req", 32'(dmem_req), 32'd0);
        checkOutput("mis_lw_flag", 32'(misalign_o), 32'd1);
        checkOutput("mis_lw_valid", 32'(wb_valid), 32'd1);
        checkOutput("mis_lw_we", 32'(wb_we), 32'd0);
        step();
        checkOutput("mis_pulse", 32'(misalign_o), 32'd0);
        applyStimulus(OP_STORE, 32'h201, 32'h55, 3'b001, 5'd0);
        checkOutput("mis_sh_req", 32'(dmem_req), 32'd0);
        checkOutput("mis_sh_flag", 32'(misalign_o), 32'd1);

        // Illegal load funct3 retires as a no-op without a flag
        applyStimulus(OP_LOAD, 32'h300, 32'd0, 3'b011, 5'd6);
        checkOutput("ill_req", 32'(dmem_req), 32'd0);
        checkOutput("ill_valid", 32'(wb_valid), 32'd1);
        checkOutput("ill_we", 32'(wb_we), 32'd0);
        checkOutput("ill_flag", 32'(misalign_o), 32'd0);

        // Timeout: request stays high for exactly 16 cycles
        applyStimulus(OP_LOAD, 32'h300, 32'd0, 3'b010, 5'd7);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dmem_req) break;
            cnt++;
            step();
        end
        checkOutput("tmo_cycles", 32'(cnt), 32'd16);
        checkOutput("tmo_req", 32'(dmem_req), 32'd0);
        checkOutput("tmo_err", 32'(bus_err_o), 32'd1);
        checkOutput("tmo_valid", 32'(wb_valid), 32'd1);
        checkOutput("tmo_we", 32'(wb_we), 32'd0);
        checkOutput("tmo_ready", 32'(ready_o), 32'd1);

        // Ack on the same edge as expiry wins
        dmem_rdata = 32'h13572468;
        applyStimulus(OP_LOAD, 32'h300, 32'd0, 3'b010, 5'd7);
        for (int i = 0; i < 15; i++) step();
        checkOutput("race_req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checkOutput("race_err", 32'(bus_err_o), 32'd0);
        checkOutput("race_valid", 32'(wb_valid), 32'd1);
        checkOutput("race_we", 32'(wb_we), 32'd1);
        checkOutput("race_data", wb_data, 32'h13572468);

        // Reset mid-access abandons it; a late ack is ignored
        applyStimulus(OP_LOAD, 32'h400, 32'd0, 3'b010, 5'd8);
        checkOutput("rma_busy", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("rma_req", 32'(dmem_req), 32'd0);
        checkOutput("rma_valid", 32'(wb_valid), 32'd0);
        checkOutput("rma_ready", 32'(ready_o), 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checkOutput("rma_lateack", 32'(wb_valid), 32'd0);
        checkOutput("rma_req2", 32'(dmem_req), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
